// File: rtl/arb_agent_pkg.sv
// arb_agent_pkg: shared types and default parameters for the REQ/GNT
// requester agent (arb_req_agent) and its command queue (arb_cmd_fifo).
package arb_agent_pkg;

  localparam int DEF_LEN_W      = 4;   // burst length field width
  localparam int DEF_FIFO_DEPTH = 4;   // command queue depth (power of two)
  localparam int DEF_TIMEOUT    = 15;  // REQ-without-GNT cycles before back-off

  // Agent phases; req is asserted only in ST_REQ and ST_OWN.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_OWN,
    ST_GAP,
    ST_BACKOFF
  } state_t;

endpackage

// File: rtl/arb_cmd_fifo.sv
// arb_cmd_fifo: synchronous command FIFO with wrap-bit pointers.
// Ports:
//   clk, rst          clock, asynchronous active-high reset (empties queue)
//   push, push_data   write request (ignored when full) and data
//   pop               read request (ignored when empty)
//   full, empty       status
//   head              current head entry (valid when !empty)
module arb_cmd_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);

  // One extra MSB per pointer distinguishes full from empty when the
  // address bits match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are meaningful, and an unreset array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/arb_req_agent.sv
// arb_req_agent: requester side of a fixed-priority REQ/GNT arbiter.
// Queues burst commands, raises req, counts granted beats, drops req for one
// cycle between bursts, and flags grant timeouts and spurious grants.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   cmd_valid      client offers a command; cmd_len = beats - 1
//   cmd_ready      queue not full (command taken on cmd_valid && cmd_ready)
//   req            registered request to the arbiter
//   gnt            grant from the arbiter
//   beat_valid     one beat transferred this cycle
//   beat_cnt       beats remaining minus one in the current burst
//   done           one-cycle pulse after the last beat
//   timeout        one-cycle pulse when the grant watchdog expires
//   err_spurious   pulse: gnt was high while req was low
//   busy           agent active or commands pending
module arb_req_agent
  import arb_agent_pkg::*;
#(
  parameter int LEN_W      = DEF_LEN_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cmd_ready,
  output logic             req,
  input  logic             gnt,
  output logic             beat_valid,
  output logic [LEN_W-1:0] beat_cnt,
  output logic             done,
  output logic             timeout,
  output logic             err_spurious,
  output logic             busy
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t             state;
  state_t             state_nx;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [LEN_W-1:0]   head_len;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               wd_expire;
  logic               last_beat;

  arb_cmd_fifo #(
    .WIDTH (LEN_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cmd_valid && cmd_ready),
    .push_data (cmd_len),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head_len)
  );

  // A zero TIMEOUT disables the watchdog entirely.
  assign wd_expire = (TIMEOUT != 0) && (wait_cnt == WAIT_W'(TIMEOUT));
  assign last_beat = (state == ST_OWN) && gnt && (beat_cnt == '0);

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    fifo_pop = 1'b0;
    unique case (state)
      ST_IDLE: if (!fifo_empty) state_nx = ST_REQ;
      ST_REQ: begin
        if (gnt) begin
          state_nx = ST_OWN;
          fifo_pop = 1'b1;
        end else if (wd_expire) begin
          state_nx = ST_BACKOFF;
        end
      end
      // gnt low in OWN means a higher-priority requester preempted us: hold.
      ST_OWN:     if (last_beat) state_nx = ST_GAP;
      ST_GAP:     state_nx = fifo_empty ? ST_IDLE : ST_REQ;
      ST_BACKOFF: state_nx = ST_REQ;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      req          <= 1'b0;
      beat_cnt     <= '0;
      wait_cnt     <= '0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      state        <= state_nx;
      req          <= (state_nx == ST_REQ) || (state_nx == ST_OWN);
      done         <= last_beat;
      timeout      <= (state == ST_REQ) && !gnt && wd_expire;
      err_spurious <= gnt && !req;

      if ((state == ST_REQ) && gnt) begin
        beat_cnt <= head_len;
      end else if ((state == ST_OWN) && gnt && (beat_cnt != '0)) begin
        beat_cnt <= beat_cnt - {{(LEN_W-1){1'b0}}, 1'b1};
      end

      // Count only consecutive ungranted REQ cycles; any exit clears it.
      if ((state == ST_REQ) && (state_nx == ST_REQ)) begin
        wait_cnt <= wait_cnt + {{(WAIT_W-1){1'b0}}, 1'b1};
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  assign cmd_ready  = !fifo_full;
  assign beat_valid = (state == ST_OWN) && gnt;
  assign busy       = (state != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_arb_req_agent.sv
module tb_arb_req_agent;

  localparam int LEN_W   = 4;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;

  // Reference-model phases (the bench's own view of the agent's behaviour).
  localparam int P_IDLE = 0, P_REQ = 1, P_OWN = 2, P_GAP = 3, P_BACKOFF = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_ready;
  logic             req;
  logic             gnt;
  logic             beat_valid;
  logic [LEN_W-1:0] beat_cnt;
  logic             done;
  logic             timeout;
  logic             err_spurious;
  logic             busy;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model state.
  int m_ph;
  int m_q[$];
  int m_cnt;
  int m_wait;
  bit m_done, m_to, m_spur;

  // Per-cycle observations, sampled at the falling edge inside step().
  bit o_req, o_beat, o_done, o_to, o_spur, o_busy, o_ready;

  arb_req_agent #(
    .LEN_W      (LEN_W),
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_len      (cmd_len),
    .cmd_ready    (cmd_ready),
    .req          (req),
    .gnt          (gnt),
    .beat_valid   (beat_valid),
    .beat_cnt     (beat_cnt),
    .done         (done),
    .timeout      (timeout),
    .err_spurious (err_spurious),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not finish, got running, want finished");
    $fatal(1);
  end

  task automatic model_reset();
    m_ph = P_IDLE;
    m_q.delete();
    m_cnt = 0;
    m_wait = 0;
    m_done = 0;
    m_to = 0;
    m_spur = 0;
  endtask

  // Advance the model by one clock edge given the inputs of the ending cycle.
  task automatic model_clock(input bit cv, input int len, input bit g);
    bit req_now  = (m_ph == P_REQ) || (m_ph == P_OWN);
    bit full_now = (m_q.size() >= DEPTH);
    int nph      = m_ph;
    m_spur = g && !req_now;
    m_done = (m_ph == P_OWN) && g && (m_cnt == 0);
    m_to   = 0;
    case (m_ph)
      P_IDLE: if (m_q.size() > 0) nph = P_REQ;
      P_REQ: begin
        if (g) begin
          nph = P_OWN;
          m_cnt = m_q.pop_front();
        end else if (TIMEOUT != 0 && m_wait == TIMEOUT) begin
          nph = P_BACKOFF;
          m_to = 1;
        end else begin
          m_wait++;
        end
      end
      P_OWN: if (g) begin
        if (m_cnt == 0) nph = P_GAP;
        else m_cnt--;
      end
      P_GAP:     nph = (m_q.size() > 0) ? P_REQ : P_IDLE;
      P_BACKOFF: nph = P_REQ;
      default:   nph = P_IDLE;
    endcase
    if (nph != P_REQ) m_wait = 0;
    if (cv && !full_now) m_q.push_back(len);
    m_ph = nph;
  endtask

  // Called just after a rising edge: drive inputs for one cycle, compare all
  // outputs to the model at the falling edge, then advance the model.
  task automatic step(input bit cv, input int len, input bit g);
    logic [10:0] exp_v, got_v;
    cmd_valid = cv;
    cmd_len   = LEN_W'(len);
    gnt       = g;
    @(negedge clk);
    exp_v = {(m_q.size() < DEPTH), (m_ph == P_REQ || m_ph == P_OWN),
             (m_ph == P_OWN) && g, 4'(m_cnt), m_done, m_to, m_spur,
             (m_ph != P_IDLE) || (m_q.size() != 0)};
    got_v = {cmd_ready, req, beat_valid, beat_cnt, done, timeout,
             err_spurious, busy};
    vectors++;
    if (got_v !== exp_v) begin
      miscompares++;
      $display("FAIL model_cycle t=%0t: got {rdy,req,beat,cnt,done,to,spur,busy}=%b want %b",
               $time, got_v, exp_v);
    end
    o_req = req; o_beat = beat_valid; o_done = done; o_to = timeout;
    o_spur = err_spurious; o_busy = busy; o_ready = cmd_ready;
    @(posedge clk);
    model_clock(cv, len, g);
    #1;
  endtask

  task automatic expect_int(input string name, input int got, input int want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    logic [10:0] got_v;
    rst = 1'b1; cmd_valid = 1'b0; cmd_len = '0; gnt = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    got_v = {cmd_ready, req, beat_valid, beat_cnt, done, timeout, err_spurious, busy};
    vectors++;
    if (got_v !== 11'b1_0_0_0000_0_0_0_0) begin
      miscompares++;
      $display("FAIL reset_values: got %b want %b", got_v, 11'b1_0_0_0000_0_0_0_0);
    end
    @(posedge clk);
    #1;
  endtask

  // cmd_len=2 with gnt tied high.
  task automatic test_single_burst();
    int first_req = -1, beats = 0, dones = 0, gap_req = 1;
    step(1, 2, 1);
    for (int k = 1; k < 10; k++) begin
      step(0, 0, 1);
      if (o_req && first_req < 0) first_req = k;
      beats += int'(o_beat);
      dones += int'(o_done);
      if (k == 6) gap_req = int'(o_req);
    end
    expect_int("single_req_latency", first_req, 2);
    expect_int("single_beats", beats, 3);
    expect_int("single_done_count", dones, 1);
    expect_int("single_req_low_after_burst", gap_req, 0);
    expect_int("single_busy_end", int'(o_busy), 0);
  endtask

  // Fill the queue with gnt low, then release gnt and drain.
  task automatic test_fill_and_drain();
    int dones = 0, gaps = 0, low_run = 0, n = 0;
    bit seen_req = 0;
    for (int i = 0; i < DEPTH; i++) step(1, $urandom_range(0, 15), 0);
    step(1, 7, 0);  // fifth offer while full
    expect_int("fill_cmd_ready_full", int'(o_ready), 0);
    while (n < 300) begin
      step(0, 0, 1);
      n++;
      dones += int'(o_done);
      if (o_req) begin
        if (seen_req && low_run > 0) begin
          expect_int("fill_gap_len", low_run, 1);
          gaps++;
        end
        low_run = 0;
        seen_req = 1;
      end else if (seen_req) begin
        low_run++;
      end
      if (!o_busy) break;
    end
    expect_int("fill_drained", int'(o_busy), 0);
    expect_int("fill_done_count", dones, DEPTH);
    expect_int("fill_gap_count", gaps, DEPTH - 1);
  endtask

  // cmd_len=3 with a two-cycle preemption in the middle of the burst.
  task automatic test_preempt();
    bit gp [10] = '{1, 1, 1, 0, 0, 1, 1, 0, 0, 0};
    int beats = 0, dones = 0, last_beat = -1, done_at = -1, req_drops = 0;
    step(1, 3, 0);
    step(0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      step(0, 0, gp[k]);
      if (o_beat) begin beats++; last_beat = k; end
      if (o_done) begin dones++; done_at = k; end
      if (k >= 1 && k <= 6 && !o_req) req_drops++;
    end
    expect_int("preempt_beats", beats, 4);
    expect_int("preempt_req_held", req_drops, 0);
    expect_int("preempt_done_count", dones, 1);
    expect_int("preempt_done_after_last", done_at, last_beat + 1);
  endtask

  // gnt never asserted: watchdog back-off, command stays pending.
  task automatic test_watchdog();
    int first_req = -1, to_at = -1, tos = 0, n = 0;
    bit req_at_to = 1, req_after = 0, busy_at_to = 0;
    step(1, $urandom_range(0, 15), 0);
    for (int k = 1; k < 26; k++) begin
      step(0, 0, 0);
      if (o_req && first_req < 0) first_req = k;
      if (o_to) begin
        tos++;
        to_at = k;
        req_at_to = o_req;
        busy_at_to = o_busy;
      end
      if (to_at >= 0 && k == to_at + 1) req_after = o_req;
    end
    expect_int("wd_timeout_delay", to_at - first_req, TIMEOUT + 1);
    expect_int("wd_timeout_count", tos, 1);
    expect_int("wd_req_low_in_backoff", int'(req_at_to), 0);
    expect_int("wd_rerequest", int'(req_after), 1);
    expect_int("wd_still_busy", int'(busy_at_to), 1);
    while (o_busy && n < 60) begin step(0, 0, 1); n++; end
    expect_int("wd_drained", int'(o_busy), 0);
  endtask

  // Spurious grant while idle, then asynchronous reset in the middle of OWN.
  task automatic test_spurious_and_reset();
    step(0, 0, 1);
    step(0, 0, 0);
    expect_int("spur_pulse", int'(o_spur), 1);
    expect_int("spur_state_idle", int'(o_busy || o_req), 0);
    step(0, 0, 0);
    expect_int("spur_one_cycle", int'(o_spur), 0);
    step(1, 5, 0);
    step(1, 2, 0);
    step(0, 0, 1);
    step(0, 0, 1);
    gnt = 1'b1;
    #2 rst = 1'b1;
    #1;
    expect_int("rst_req_drop", int'(req), 0);
    expect_int("rst_cmd_ready", int'(cmd_ready), 1);
    expect_int("rst_no_done", int'(done), 0);
    expect_int("rst_flush_busy", int'(busy), 0);
    @(negedge clk);
    gnt = 1'b0;
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    step(0, 0, 0);
    expect_int("rst_no_done_after", int'(o_done), 0);
  endtask

  task automatic test_random();
    int n = 0;
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 15), $urandom_range(0, 3) != 0);
    end
    while (o_busy && n < 200) begin step(0, 0, 1); n++; end
    expect_int("random_drained", int'(o_busy), 0);
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_fill_and_drain();
    test_preempt();
    test_watchdog();
    test_spurious_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
